// File: rtl/brc_pkg.sv
// Purpose: shared types for the branch resolve controller (state enum, queue entry, branch opcode).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package brc_pkg;

   // RV32 conditional-branch major opcode, opcode[6:2]
   localparam logic [4:0] BRANCH_OPCODE = 5'b11000;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } brc_state_t;

   // One in-flight predicted branch, captured at IF
   typedef struct packed {
      logic [31:0] pc;
      logic        pred_jump;
      logic [31:0] pred_target;
   } brc_entry_t;

   localparam int ENTRY_W = $bits(brc_entry_t);

endpackage

// File: rtl/brc_fifo.sv
// Purpose: DEPTH-entry circular queue with synchronous clear; head is read combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push into a full queue is only taken when a pop happens in the same cycle; pops on empty are ignored.
//
// Ports: clk, rst (sync, active-high), push/pop/clear strobes, wdata in, rdata (head) out,
//        count (post-edge occupancy), full, empty.
module brc_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full queue still accepts a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Purpose: queues IF branch predictions in order and checks the oldest against the EX resolution,
//          producing flush/redirect, predictor update, mispredict class and accuracy counters.
// Latency: all result outputs are registered, one cycle after the resolving pop, one-cycle pulses.
// Backpressure: full tells IF to stall; pushes are blocked for HOLD_CYC non-stalled cycles after a flush.
//
// Ports: clk, rst (sync, active-high), stall; IF side if_valid/if_is_branch/if_pc/if_pred_jump/
//        if_pred_target; EX side e_valid/e_is_branch/e_real_jump/e_target; outputs flush, redirect_pc,
//        upd_valid, upd_taken, t_pnt, nt_pt, tgt_miss, full, err (sticky), right_cnt, wrong_cnt.
// Build option: define BRC_STATS_EN to implement right_cnt/wrong_cnt; otherwise both read 0.
module branch_resolve_ctrl
   import brc_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int HOLD_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        if_valid,
   input  logic        if_is_branch,
   input  logic [31:0] if_pc,
   input  logic        if_pred_jump,
   input  logic [31:0] if_pred_target,
   input  logic        e_valid,
   input  logic        e_is_branch,
   input  logic        e_real_jump,
   input  logic [31:0] e_target,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic        upd_valid,
   output logic        upd_taken,
   output logic        t_pnt,
   output logic        nt_pt,
   output logic        tgt_miss,
   output logic        full,
   output logic        err,
   output logic [31:0] right_cnt,
   output logic [31:0] wrong_cnt
);

   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

   brc_state_t          state, state_nxt;
   logic [HW-1:0]       hold_cnt, hold_nxt;
   brc_entry_t          wr_entry, head;
   logic [ENTRY_W-1:0]  head_raw;
   logic [$clog2(DEPTH):0] count;
   logic                empty;
   logic                push, pop, vpop;
   logic                c_tpnt, c_ntpt, c_tgt, mispredict;
   logic [31:0]         redir;

   assign push = if_valid & if_is_branch & ~stall & (state == RUN);
   assign pop  = e_valid & e_is_branch & ~stall;
   assign vpop = pop & ~empty;

   assign wr_entry = '{pc: if_pc, pred_jump: if_pred_jump, pred_target: if_pred_target};
   assign head     = brc_entry_t'(head_raw);

   assign c_tpnt     = vpop &  e_real_jump & ~head.pred_jump;
   assign c_ntpt     = vpop & ~e_real_jump &  head.pred_jump;
   assign c_tgt      = vpop &  e_real_jump &  head.pred_jump & (e_target != head.pred_target);
   assign mispredict = c_tpnt | c_ntpt | c_tgt;
   // Only the not-taken case falls through; every other mispredict goes to the resolved target
   assign redir      = c_ntpt ? (head.pc + 32'd4) : e_target;

   // A mispredict clears the queue: everything younger than the head is wrong-path
   brc_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (mispredict),
      .wdata (wr_entry),
      .rdata (head_raw),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // The refill window only advances on non-stalled cycles, so stalls stretch it
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      if (mispredict) begin
         state_nxt = HOLD;
         hold_nxt  = HOLD_LOAD;
      end else if (state == HOLD && !stall) begin
         if (hold_cnt == '0) state_nxt = RUN;
         else                hold_nxt  = hold_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush       <= 1'b0;
         redirect_pc <= '0;
         upd_valid   <= 1'b0;
         upd_taken   <= 1'b0;
         t_pnt       <= 1'b0;
         nt_pt       <= 1'b0;
         tgt_miss    <= 1'b0;
         err         <= 1'b0;
      end else begin
         flush       <= mispredict;
         redirect_pc <= mispredict ? redir : 32'd0;
         upd_valid   <= vpop;
         upd_taken   <= vpop & e_real_jump;
         t_pnt       <= c_tpnt;
         nt_pt       <= c_ntpt;
         tgt_miss    <= c_tgt;
         // Overflow: push into a full queue with nothing leaving; underflow: pop on empty
         if ((push & full & ~vpop) | (pop & empty)) err <= 1'b1;
      end
   end

`ifdef BRC_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         right_cnt <= '0;
         wrong_cnt <= '0;
      end else begin
         if (vpop & ~mispredict) right_cnt <= right_cnt + 32'd1;
         if (mispredict)         wrong_cnt <= wrong_cnt + 32'd1;
      end
   end
`else
   assign right_cnt = 32'd0;
   assign wrong_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Purpose: directed testbench for branch_resolve_ctrl (DEPTH=4, HOLD_CYC=2).
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercises full/overflow, refill hold and stall-extended hold.
module tb_branch_resolve_ctrl;
   import brc_pkg::*;

`ifdef BRC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, stall;
   logic        if_valid, if_is_branch, if_pred_jump;
   logic [31:0] if_pc, if_pred_target;
   logic        e_valid, e_is_branch, e_real_jump;
   logic [31:0] e_target;
   logic        flush, upd_valid, upd_taken, t_pnt, nt_pt, tgt_miss, full, err;
   logic [31:0] redirect_pc, right_cnt, wrong_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.DEPTH(4), .HOLD_CYC(2)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .if_valid(if_valid), .if_is_branch(if_is_branch), .if_pc(if_pc),
      .if_pred_jump(if_pred_jump), .if_pred_target(if_pred_target),
      .e_valid(e_valid), .e_is_branch(e_is_branch), .e_real_jump(e_real_jump), .e_target(e_target),
      .flush(flush), .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_taken(upd_taken),
      .t_pnt(t_pnt), .nt_pt(nt_pt), .tgt_miss(tgt_miss), .full(full), .err(err),
      .right_cnt(right_cnt), .wrong_cnt(wrong_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt_exp(input int n);
      return STATS ? 32'(n) : 32'd0;
   endfunction

   task automatic idle();
      stall = 0; if_valid = 0; if_is_branch = 0; if_pc = 0; if_pred_jump = 0; if_pred_target = 0;
      e_valid = 0; e_is_branch = 0; e_real_jump = 0; e_target = 0;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic pj, input logic [31:0] pt);
      if_valid = 1; if_is_branch = 1; if_pc = pc; if_pred_jump = pj; if_pred_target = pt;
   endtask

   task automatic set_pop(input logic rj, input logic [31:0] tgt);
      e_valid = 1; e_is_branch = 1; e_real_jump = rj; e_target = tgt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;
      // Reset state
      chk("rst_flush", flush, 0);
      chk("rst_redirect", redirect_pc, 0);
      chk("rst_upd", upd_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_full", full, 0);
      chk("rst_count", 32'(dut.u_fifo.count), 0);
      chk("rst_state", 32'(dut.state), 32'(RUN));
      chk("rst_right", right_cnt, 0);
      chk("rst_wrong", wrong_cnt, 0);

      // Taken, predicted not-taken
      set_push(32'h100, 0, 32'h0); tick(); idle();
      chk("t1_count_push", 32'(dut.u_fifo.count), 1);
      set_pop(1, 32'h200); tick(); idle();
      chk("t1_flush", flush, 1);
      chk("t1_tpnt", t_pnt, 1);
      chk("t1_ntpt", nt_pt, 0);
      chk("t1_tgt", tgt_miss, 0);
      chk("t1_redirect", redirect_pc, 32'h200);
      chk("t1_upd_valid", upd_valid, 1);
      chk("t1_upd_taken", upd_taken, 1);
      chk("t1_count", 32'(dut.u_fifo.count), 0);
      chk("t1_wrong", wrong_cnt, cnt_exp(1));
      tick();
      chk("t1_flush_pulse", flush, 0);
      tick();
      chk("t1_state_run", 32'(dut.state), 32'(RUN));

      // Not-taken, predicted taken: fall-through is pc+4
      set_push(32'h3FC, 1, 32'h400); tick(); idle();
      set_pop(0, 32'h0); tick(); idle();
      chk("t2_ntpt", nt_pt, 1);
      chk("t2_tpnt", t_pnt, 0);
      chk("t2_redirect", redirect_pc, 32'h400);
      chk("t2_upd_taken", upd_taken, 0);
      tick(); tick();
      set_push(32'hFFFF_FFFC, 1, 32'h10); tick(); idle();
      set_pop(0, 32'h0); tick(); idle();
      chk("t2_wrap_flush", flush, 1);
      chk("t2_wrap_redirect", redirect_pc, 32'h0);
      chk("t2_wrong", wrong_cnt, cnt_exp(3));
      tick(); tick();

      // Taken as predicted, but to a different target
      set_push(32'h500, 1, 32'h80); tick(); idle();
      set_pop(1, 32'h84); tick(); idle();
      chk("t3_tgt_miss", tgt_miss, 1);
      chk("t3_redirect", redirect_pc, 32'h84);
      chk("t3_wrong", wrong_cnt, cnt_exp(4));
      tick(); tick();

      // Three correct predictions resolved in order
      set_push(32'h10, 0, 32'h0);  tick();
      set_push(32'h20, 1, 32'h80); tick();
      set_push(32'h30, 1, 32'h90); tick(); idle();
      chk("t4_count3", 32'(dut.u_fifo.count), 3);
      set_pop(0, 32'h0); tick(); idle();
      chk("t4_upd0", upd_valid, 1);
      chk("t4_taken0", upd_taken, 0);
      chk("t4_flush0", flush, 0);
      set_pop(1, 32'h80); tick(); idle();
      chk("t4_upd1", upd_valid, 1);
      chk("t4_taken1", upd_taken, 1);
      chk("t4_flush1", flush, 0);
      set_pop(1, 32'h90); tick(); idle();
      chk("t4_upd2", upd_valid, 1);
      chk("t4_flush2", flush, 0);
      chk("t4_right", right_cnt, cnt_exp(3));
      chk("t4_count0", 32'(dut.u_fifo.count), 0);
      tick();
      chk("t4_upd_idle", upd_valid, 0);

      // Fill, overflow, then push+pop while full
      for (int i = 0; i < 4; i++) begin
         set_push(32'h40 + 32'(4 * i), 0, 32'h0); tick();
      end
      idle();
      chk("t5_full", full, 1);
      chk("t5_err0", err, 0);
      set_push(32'h50, 0, 32'h0); tick(); idle();
      chk("t5_err_ovf", err, 1);
      chk("t5_count_ovf", 32'(dut.u_fifo.count), 4);
      set_push(32'h54, 0, 32'h0); set_pop(0, 32'h0); tick(); idle();
      chk("t5_count_pp", 32'(dut.u_fifo.count), 4);
      chk("t5_err_pp", err, 1);
      chk("t5_upd_pp", upd_valid, 1);
      chk("t5_right", right_cnt, cnt_exp(4));

      // Mispredict with a same-cycle push, then the stall-stretched refill hold
      set_push(32'h58, 0, 32'h0); set_pop(1, 32'h500); tick();
      chk("t6_flush", flush, 1);
      chk("t6_redirect", redirect_pc, 32'h500);
      chk("t6_count", 32'(dut.u_fifo.count), 0);
      chk("t6_wrong", wrong_cnt, cnt_exp(5));
      idle(); set_push(32'h60, 0, 32'h0); stall = 1; tick();
      chk("t6_hold_a", 32'(dut.u_fifo.count), 0);
      stall = 0; tick();
      chk("t6_hold_b", 32'(dut.u_fifo.count), 0);
      stall = 1; tick();
      chk("t6_hold_c", 32'(dut.u_fifo.count), 0);
      chk("t6_state_hold", 32'(dut.state), 32'(HOLD));
      stall = 0; tick();
      chk("t6_hold_d", 32'(dut.u_fifo.count), 0);
      chk("t6_state_run", 32'(dut.state), 32'(RUN));
      tick();
      chk("t6_accept", 32'(dut.u_fifo.count), 1);
      set_push(32'h64, 0, 32'h0); tick(); idle();
      chk("t6_count2", 32'(dut.u_fifo.count), 2);

      // Reset arriving together with a mispredict pop
      set_pop(1, 32'h700); rst = 1; tick(); rst = 0; idle();
      chk("t7_flush", flush, 0);
      chk("t7_tpnt", t_pnt, 0);
      chk("t7_redirect", redirect_pc, 0);
      chk("t7_upd", upd_valid, 0);
      chk("t7_err", err, 0);
      chk("t7_count", 32'(dut.u_fifo.count), 0);
      chk("t7_state", 32'(dut.state), 32'(RUN));
      chk("t7_wrong", wrong_cnt, 0);
      chk("t7_right", right_cnt, 0);

      // Pop on an empty queue is an underflow
      set_pop(1, 32'h0); tick(); idle();
      chk("t8_err_udf", err, 1);
      chk("t8_upd_udf", upd_valid, 0);
      chk("t8_flush_udf", flush, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequencing controller for the branch predictor. It records each predicted conditional branch in an in-order queue from IF, then compares the oldest entry against the Execute-stage resolution. It produces a registered flush/redirect, a predictor-update strobe, mispredict classification and accuracy counters. It sits between IF (predictor output), EX (branch unit) and the PC mux.

## Interface
Parameters:
- DEPTH, 4: in-flight branch entries, power of two, ≥2
- HOLD_CYC, 2: non-stalled cycles after a flush during which pushes are blocked (pipeline refill)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; synchronous, active-high
- stall  in  1  pipeline hold; no push, pop or hold-count while high
- if_valid  in  1  IF instruction valid
- if_is_branch  in  1  IF opcode[6:2]==5'b11000
- if_pc  in  32  IF PC
- if_pred_jump  in  1  predictor taken decision
- if_pred_target  in  32  predicted target
- e_valid  in  1  EX instruction valid
- e_is_branch  in  1  EX op==5'b11000
- e_real_jump  in  1  resolved taken
- e_target  in  32  resolved taken target
- flush  out  1  squash IF/ID, 1-cycle pulse
- redirect_pc  out  32  PC to load when flush
- upd_valid  out  1  predictor update strobe
- upd_taken  out  1  resolved direction for update
- t_pnt  out  1  taken, predicted not-taken
- nt_pt  out  1  not-taken, predicted taken
- tgt_miss  out  1  taken/predicted taken, target differs
- full  out  1  queue count==DEPTH (combinational); IF must stall
- err  out  1  sticky: overflow push or underflow pop
- right_cnt  out  32  correct predictions
- wrong_cnt  out  32  mispredictions

## Operation
- Entry: {pc, pred_jump, pred_target}; stored when push = if_valid & if_is_branch & ~stall & state==RUN.
- pop = e_valid & e_is_branch & ~stall. Pop compares the head entry with the EX resolution:
  - real=1, pred=0: t_pnt, redirect=e_target
  - real=0, pred=1: nt_pt, redirect=pc+4 (32-bit wrap)
  - real=1, pred=1, e_target≠pred_target: tgt_miss, redirect=e_target
  - otherwise: correct, no flush
- Any mispredict: flush, queue cleared (all younger entries are wrong-path), state→HOLD.
- States:
  - RUN: push/pop enabled.
  - HOLD: pushes blocked; counter loads HOLD_CYC-1 on entry and decrements on non-stalled cycles; at 0 → RUN. Pops are still honoured, but on an empty queue a pop sets err.
- Push while full with no same-cycle pop: entry dropped, err set. Push+pop while full: legal.
- Push and mispredict pop in the same cycle: flush wins and the push is discarded.
- upd_valid=1, upd_taken=e_real_jump on every pop of a valid head.

## Timing
- flush, redirect_pc, upd_*, t_pnt, nt_pt, tgt_miss are registered: asserted the cycle after pop, for exactly one cycle.
- Counters update the same edge as the outputs.
- Queue count and full reflect the post-edge state.
- Reset values: all outputs 0, queue empty, state RUN, counters 0, err 0.
- rst mid-operation discards all entries and any pending flush.
- Stall does not mask already-registered pulses.
- Counters wrap modulo 2^32.

## Configuration
- BRC_STATS_EN defined: right_cnt/wrong_cnt implemented (wrong includes tgt_miss).
- BRC_STATS_EN undefined: counter registers removed, both outputs tied to 0; all other behaviour identical.

## Structure
- Package brc_pkg: state enum {RUN, HOLD}, entry struct typedef, opcode constant 5'b11000.
- Sub-module brc_fifo: DEPTH-entry circular queue, parameterized width, with push/pop/clear and count, full and empty outputs. The controller holds the FSM, compare logic and output registers.

## Test plan
- Predict NT at pc 0x100, EX taken to 0x200 → next cycle flush=1, t_pnt=1, redirect_pc=0x200, queue empty, wrong_cnt=1.
- Predict T at 0x3FC with target 0x400, EX not taken → nt_pt=1, redirect_pc=0x400 (=pc+4); 0xFFFFFFFC → redirect 0x0.
- Three correct branches pushed, then popped in order → no flush, right_cnt=3, upd_valid pulses three times.
- Fill DEPTH entries, then a push without a pop → err=1, count stays DEPTH; push+pop while full → count stays DEPTH, err unchanged.
- Mispredict pop with a simultaneous push → flush, count=0; pushes ignored for HOLD_CYC non-stall cycles (extended by inserted stall cycles), accepted after.
- rst asserted with 2 entries and a pending flush → next cycle all outputs 0, count 0, state RUN.
